binary_to_gray: RTL and testbench
=================================

Name: binary_to_gray

Overview:
Registered, parameterised code converter between plain binary and reflected Gray code.
- Default forward mode: binary→Gray, G[i] = B[i] ^ B[i+1], MSB passes through.
- Reverse mode: Gray→binary, via prefix XOR from the MSB.
- Sits on status/pointer paths (e.g. counters crossing to other logic) where a Gray-coded value is needed one cycle after a valid binary input.
- The default width of 3 matches the 3-bit B2..B0 → G2..G0 usage.

Parameters:
- WIDTH, 3, data width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input word qualifier
- mode  input  1  0 = binary→Gray, 1 = Gray→binary; sampled together with in_data
- in_data  input  WIDTH  value to convert; bit WIDTH-1 is MSB (B2 in the 3-bit case)
- out_valid  output  1  registered qualifier for out_data
- out_data  output  WIDTH  converted value; bit WIDTH-1 is MSB (G2 in the 3-bit case)

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0 and out_data=0 on the next edge. This dominates in_valid in the same cycle.
- Latency: exactly 1 cycle. When in_valid=1 at edge N (rst=0), out_data holds conv(in_data, mode) and out_valid=1 after edge N.
- When in_valid=0 at an edge: out_valid goes to 0 and out_data holds its previous value. out_data is don't-care for consumers while out_valid=0.
- No backpressure: a new word is accepted every cycle, and back-to-back valids produce back-to-back outputs.
- Forward conversion (mode=0):
  - out[WIDTH-1] = in[WIDTH-1]
  - out[i] = in[i] ^ in[i+1] for i < WIDTH-1
  - Equivalent to in ^ (in >> 1).
- Reverse conversion (mode=1):
  - out[WIDTH-1] = in[WIDTH-1]
  - out[i] = out[i+1] ^ in[i], i.e. XOR of all in bits at positions ≥ i.
- Purely bitwise: no overflow or carry; all-ones and all-zeros inputs are legal.
- WIDTH=1: out = in in both modes.
- Round trip: Gray→binary(binary→Gray(x)) = x for every x.
- A mode change takes effect per word; there is no state beyond the output registers.
- Reset asserted mid-stream: the word presented in the reset cycle is discarded, and accepting input resumes on the first edge with rst=0.
- No latches. Conversion logic is combinational ahead of a single register stage.

Decomposition:
- Shared package gray_pkg:
  - MODE_B2G=1'b0 and MODE_G2B=1'b1 constants.
  - Pure functions bin2gray(logic [WIDTH-1:0]) and gray2bin(...), so testbenches and other blocks reuse the golden model.
- One natural sub-module: gray_to_binary_comb, a parameterised combinational prefix-XOR chain used for mode=1.
- Forward XOR and the output register live in the top.

Test Plan:
- Exhaustive forward, WIDTH=3, mode=0, in_valid=1, inputs 000..111, one per cycle → out_data one cycle later = 000, 001, 011, 010, 110, 111, 101, 100, with out_valid=1 throughout.
- Exhaustive reverse, WIDTH=3, mode=1, inputs 000, 001, 011, 010, 110, 111, 101, 100 → out_data = 000..111 in order.
- Reset: stream valid words, assert rst for 1 cycle with in_valid=1 and in_data=101 → after that edge out_valid=0 and out_data=000; the next valid word 110 (mode=0) yields 101 one cycle after rst deasserts.
- Valid gap and hold: in_valid=1 with 011 (mode=0), then in_valid=0 with in_data=111 → out_valid pulses for one cycle with 010, then out_valid=0 and out_data stays 010.
- Mode interleave, WIDTH=8: alternate mode=0 with 0xFF → 0x80, then mode=1 with 0x80 → 0xFF, then mode=0 with 0xA5 → 0xF7.
- Random round trip, WIDTH=16: 1000 random x through mode=0, result fed back with mode=1 → final output equals x, checked against the gray_pkg functions.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and golden conversion functions for binary/reflected-Gray code.
// The functions work on 64-bit words; narrower values are zero-extended.
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  localparam int GRAY_MAX_WIDTH = 64;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero bits above a narrower word do not change the prefix XOR of the low bits.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = '0;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_binary_comb.sv
// Combinational Gray-to-binary converter: prefix XOR running down from the MSB.
module gray_to_binary_comb #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary<->Gray converter, one-cycle latency, direction chosen per word by mode.
// Handshake: a word is taken on every edge with in_valid=1 (no ready, no stall); out_valid marks out_data one edge later.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] conv;

  assign fwd = in_data ^ (in_data >> 1);

  gray_to_binary_comb #(.WIDTH(WIDTH)) u_g2b (
    .gray (in_data),
    .bin  (rev)
  );

  assign conv = (mode == MODE_G2B) ? rev : fwd;

  // out_data only loads on accepted words so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= conv;
      end
    end
  end

endmodule

// File: tb/tb_binary_to_gray.sv
// Self-checking bench for binary_to_gray at widths 1, 3, 8 and 16 against an
// arithmetic reference model kept in the bench.
module tb_binary_to_gray;

  logic clk;
  logic rst;

  logic        w1_in_valid, w1_mode, w1_out_valid;
  logic [0:0]  w1_in_data, w1_out_data;
  logic        w3_in_valid, w3_mode, w3_out_valid;
  logic [2:0]  w3_in_data, w3_out_data;
  logic        w8_in_valid, w8_mode, w8_out_valid;
  logic [7:0]  w8_in_data, w8_out_data;
  logic        w16_in_valid, w16_mode, w16_out_valid;
  logic [15:0] w16_in_data, w16_out_data;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  binary_to_gray #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .mode(w1_mode),
    .in_data(w1_in_data), .out_valid(w1_out_valid), .out_data(w1_out_data));
  binary_to_gray #(.WIDTH(3)) dut_w3 (
    .clk(clk), .rst(rst), .in_valid(w3_in_valid), .mode(w3_mode),
    .in_data(w3_in_data), .out_valid(w3_out_valid), .out_data(w3_out_data));
  binary_to_gray #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .mode(w8_mode),
    .in_data(w8_in_data), .out_valid(w8_out_valid), .out_data(w8_out_data));
  binary_to_gray #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst(rst), .in_valid(w16_in_valid), .mode(w16_mode),
    .in_data(w16_in_data), .out_valid(w16_out_valid), .out_data(w16_out_data));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: Gray of x is x xor x/2; binary of g is xor of g/2^k over all k
  function automatic logic [63:0] m_b2g(input logic [63:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [63:0] m_g2b(input logic [63:0] g);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < 64; k++) acc = acc ^ (g >> k);
    return acc;
  endfunction

  function automatic logic [63:0] m_conv(input logic m, input logic [63:0] x);
    return m ? m_g2b(x) : m_b2g(x);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: apply one word, advance past the edge, outputs then reflect it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w1(input logic v, input logic m, input logic [0:0] d);
    w1_in_valid = v; w1_mode = m; w1_in_data = d;
    step();
  endtask

  task automatic drive_w3(input logic v, input logic m, input logic [2:0] d);
    w3_in_valid = v; w3_mode = m; w3_in_data = d;
    step();
  endtask

  task automatic drive_w8(input logic v, input logic m, input logic [7:0] d);
    w8_in_valid = v; w8_mode = m; w8_in_data = d;
    step();
  endtask

  task automatic drive_w16(input logic v, input logic m, input logic [15:0] d);
    w16_in_valid = v; w16_mode = m; w16_in_data = d;
    step();
  endtask

  initial begin
    logic [2:0]  seq3;
    logic [2:0]  gray3;
    logic [7:0]  d8;
    logic [15:0] x;
    logic [15:0] g;
    logic [15:0] last;
    total = 0;
    bad = 0;
    w1_in_valid = 0;  w1_mode = 0;  w1_in_data = '0;
    w3_in_valid = 0;  w3_mode = 0;  w3_in_data = '0;
    w8_in_valid = 0;  w8_mode = 0;  w8_in_data = '0;
    w16_in_valid = 0; w16_mode = 0; w16_in_data = '0;

    rst = 1'b1;
    w3_in_valid = 1; w3_in_data = 3'b111;
    step();
    step();
    check("reset_w3_valid", 64'(w3_out_valid), 64'd0);
    check("reset_w3_data", 64'(w3_out_data), 64'd0);
    check("reset_w16_valid", 64'(w16_out_valid), 64'd0);
    check("reset_w16_data", 64'(w16_out_data), 64'd0);
    rst = 1'b0;

    // exhaustive forward: 0..7 -> 000 001 011 010 110 111 101 100
    for (int i = 0; i < 8; i++) begin
      seq3 = 3'(i);
      drive_w3(1'b1, 1'b0, seq3);
      check("fwd3_valid", 64'(w3_out_valid), 64'd1);
      check("fwd3_data", 64'(w3_out_data), m_b2g(64'(seq3)));
    end

    // exhaustive reverse: Gray sequence back to 0..7 in order
    for (int i = 0; i < 8; i++) begin
      seq3 = 3'(i);
      gray3 = seq3 ^ (seq3 >> 1);
      drive_w3(1'b1, 1'b1, gray3);
      check("rev3_valid", 64'(w3_out_valid), 64'd1);
      check("rev3_data", 64'(w3_out_data), 64'(i));
    end

    // reset mid-stream dominates a valid word
    drive_w3(1'b1, 1'b0, 3'b010);
    rst = 1'b1;
    drive_w3(1'b1, 1'b0, 3'b101);
    check("rst_mid_valid", 64'(w3_out_valid), 64'd0);
    check("rst_mid_data", 64'(w3_out_data), 64'd0);
    rst = 1'b0;
    drive_w3(1'b1, 1'b0, 3'b110);
    check("post_rst_valid", 64'(w3_out_valid), 64'd1);
    check("post_rst_data", 64'(w3_out_data), 64'b101);

    // valid gap: one-cycle pulse, then hold
    drive_w3(1'b1, 1'b0, 3'b011);
    check("gap_pulse_valid", 64'(w3_out_valid), 64'd1);
    check("gap_pulse_data", 64'(w3_out_data), 64'b010);
    drive_w3(1'b0, 1'b0, 3'b111);
    check("gap_idle_valid", 64'(w3_out_valid), 64'd0);
    check("gap_hold_data", 64'(w3_out_data), 64'b010);
    drive_w3(1'b0, 1'b1, 3'b100);
    check("gap_hold2_data", 64'(w3_out_data), 64'b010);

    // mode interleave at width 8
    drive_w8(1'b1, 1'b0, 8'hFF);
    check("w8_ff_fwd", 64'(w8_out_data), 64'h80);
    drive_w8(1'b1, 1'b1, 8'h80);
    check("w8_80_rev", 64'(w8_out_data), 64'hFF);
    drive_w8(1'b1, 1'b0, 8'hA5);
    check("w8_a5_fwd", 64'(w8_out_data), 64'hF7);
    check("w8_valid", 64'(w8_out_valid), 64'd1);
    for (int i = 0; i < 40; i++) begin
      d8 = 8'($urandom_range(0, 255));
      drive_w8(1'b1, i[0], d8);
      check("w8_rand", 64'(w8_out_data), m_conv(i[0], 64'(d8)));
    end
    drive_w8(1'b0, 1'b0, 8'h00);
    check("w8_idle_valid", 64'(w8_out_valid), 64'd0);

    // width 1: identity in both modes
    for (int i = 0; i < 4; i++) begin
      drive_w1(1'b1, i[1], i[0:0]);
      check("w1_ident", 64'(w1_out_data), 64'(i[0]));
    end

    // width 16 random round trip with idle gaps
    last = '0;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom_range(0, 65535));
      if (i == 0) x = 16'hFFFF;
      if (i == 1) x = 16'h0000;
      exp_q.push_back(x);
      drive_w16(1'b1, 1'b0, x);
      check("w16_fwd", 64'(w16_out_data), m_b2g(64'(x)));
      g = w16_out_data;
      drive_w16(1'b1, 1'b1, g);
      check("w16_roundtrip", 64'(w16_out_data), 64'(exp_q.pop_front()));
      last = x;
      if ($urandom_range(0, 7) == 0) begin
        drive_w16(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
        check("w16_idle_valid", 64'(w16_out_valid), 64'd0);
        check("w16_idle_hold", 64'(w16_out_data), 64'(last));
      end
    end
    check("w16_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
